// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX stage of the RV64 pipeline.
// It decodes the ID fields into ALU controls, registers the operands, and
// forwards results from EX/MEM and MEM/WB. It also inserts load-use bubbles
// and holds the instruction while the EX stage stalls.
// Optional build macro ALU_ISSUE_PERF_EN adds the bubble_count/stall_count
// saturating counters.
module alu_issue_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_op,
  output logic            ex_shift,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic [XLEN-1:0] ex_store_data,
`ifdef ALU_ISSUE_PERF_EN
  output logic [31:0]     bubble_count,
  output logic [31:0]     stall_count,
`endif
  output logic            illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

  state_t state_p1, state_nxt;

  // Decoded fields of the ID instruction
  logic [3:0] dec_alu_op;
  logic       dec_shift, dec_b_imm, dec_rs2_used, dec_reg_write;
  logic       dec_mem_read, dec_mem_write, dec_branch, dec_illegal;
  logic [3:0] f3_op;
  logic       f3_shift, f3_ok;

  // EX-side registers
  logic [RA_W-1:0] rs1_p1, rs2_p1, rd_p1;
  logic [XLEN-1:0] a_p1, s2_p1, imm_p1;
  logic [3:0]      alu_op_p1;
  logic            b_imm_p1, shift_p1, rw_p1, mr_p1, mw_p1, br_p1, illegal_p1;
  logic            vld_p1;

  // Control-path strobes
  logic hazard, load_en, hold_en, clr_ctl, illegal_nxt;
  logic fwd1_ex, fwd1_wb, fwd2_ex, fwd2_wb;
  logic [XLEN-1:0] fwd_a, fwd_s2;

  // Translate opcode/funct3/funct7b5 into ALU controls and operand select
  always_comb begin
    f3_op    = ALU_ADD;
    f3_shift = 1'b0;
    f3_ok    = 1'b1;
    case (id_funct3)
      3'b000:  f3_op = ALU_ADD;
      3'b111:  f3_op = ALU_AND;
      3'b110:  f3_op = ALU_OR;
      3'b010:  f3_op = ALU_SLT;
      3'b001:  f3_shift = 1'b1;
      default: f3_ok = 1'b0;
    endcase

    dec_alu_op    = ALU_ADD;
    dec_shift     = 1'b0;
    dec_b_imm     = 1'b0;
    dec_rs2_used  = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_illegal   = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec_alu_op    = (id_funct3 == 3'b000 && id_funct7b5) ? ALU_SUB : f3_op;
        dec_shift     = f3_shift;
        dec_rs2_used  = 1'b1;
        dec_reg_write = (id_rd != '0);
        dec_illegal   = ~f3_ok;
      end
      OP_I: begin
        dec_alu_op    = f3_op;
        dec_shift     = f3_shift;
        dec_b_imm     = 1'b1;
        dec_reg_write = (id_rd != '0);
        dec_illegal   = ~f3_ok;
      end
      OP_LOAD: begin
        dec_b_imm     = 1'b1;
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_STORE: begin
        dec_b_imm     = 1'b1;
        dec_rs2_used  = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec_alu_op   = ALU_SUB;
        dec_rs2_used = 1'b1;
        dec_branch   = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign vld_p1 = (state_p1 == FULL);

  // A load in EX cannot supply its data to the instruction right behind it
  assign hazard = vld_p1 && mr_p1 && (rd_p1 != '0) &&
                  ((rd_p1 == id_rs1) || (dec_rs2_used && (rd_p1 == id_rs2)));

  // EX/MEM wins over MEM/WB; x0 is never forwarded
  assign fwd1_ex = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_p1);
  assign fwd1_wb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_p1);
  assign fwd2_ex = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_p1);
  assign fwd2_wb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_p1);
  assign fwd_a   = fwd1_ex ? exmem_result : (fwd1_wb ? memwb_data : a_p1);
  assign fwd_s2  = fwd2_ex ? exmem_result : (fwd2_wb ? memwb_data : s2_p1);

  // Next-state and handshake: flush, then stall, then hazard, then accept
  always_comb begin
    state_nxt   = state_p1;
    id_ready    = 1'b0;
    load_en     = 1'b0;
    hold_en     = 1'b0;
    clr_ctl     = 1'b0;
    illegal_nxt = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      clr_ctl   = 1'b1;
    end else if (state_p1 == FULL && !ex_ready) begin
      hold_en = 1'b1;
    end else if (hazard && id_valid && (ex_ready || !vld_p1)) begin
      state_nxt = BUBBLE;
      clr_ctl   = 1'b1;
    end else begin
      id_ready = 1'b1;
      if (id_valid) begin
        load_en = 1'b1;
        if (dec_illegal) begin
          state_nxt   = EMPTY;
          clr_ctl     = 1'b1;
          illegal_nxt = 1'b1;
        end else begin
          state_nxt = FULL;
        end
      end else begin
        state_nxt = EMPTY;
        clr_ctl   = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p1 <= EMPTY;
    else        state_p1 <= state_nxt;
  end

  // ---- ID -> EX boundary: operand and control registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      a_p1       <= '0;
      s2_p1      <= '0;
      imm_p1     <= '0;
      alu_op_p1  <= '0;
      b_imm_p1   <= 1'b0;
      shift_p1   <= 1'b0;
      rw_p1      <= 1'b0;
      mr_p1      <= 1'b0;
      mw_p1      <= 1'b0;
      br_p1      <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      illegal_p1 <= illegal_nxt;
      if (hold_en) begin
        // Keep forwarded values alive after their producer retires
        a_p1  <= fwd_a;
        s2_p1 <= fwd_s2;
      end else if (load_en) begin
        rs1_p1    <= id_rs1;
        rs2_p1    <= id_rs2;
        rd_p1     <= id_rd;
        a_p1      <= id_rs1_data;
        s2_p1     <= id_rs2_data;
        imm_p1    <= id_imm;
        alu_op_p1 <= dec_alu_op;
        b_imm_p1  <= dec_b_imm;
        shift_p1  <= dec_shift;
      end
      if (load_en && !dec_illegal) begin
        rw_p1 <= dec_reg_write;
        mr_p1 <= dec_mem_read;
        mw_p1 <= dec_mem_write;
        br_p1 <= dec_branch;
      end else if (clr_ctl) begin
        rw_p1 <= 1'b0;
        mr_p1 <= 1'b0;
        mw_p1 <= 1'b0;
        br_p1 <= 1'b0;
      end
    end
  end

  assign ex_valid      = vld_p1;
  assign ex_a          = fwd_a;
  assign ex_b          = b_imm_p1 ? imm_p1 : fwd_s2;
  assign ex_store_data = fwd_s2;
  assign ex_alu_op     = alu_op_p1;
  assign ex_shift      = shift_p1;
  assign ex_rd         = rd_p1;
  assign ex_reg_write  = rw_p1;
  assign ex_mem_read   = mr_p1;
  assign ex_mem_write  = mw_p1;
  assign ex_branch     = br_p1;
  assign illegal       = illegal_p1;

`ifdef ALU_ISSUE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating counts of inserted bubbles and EX stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
      stall_count  <= '0;
    end else begin
      if (state_nxt == BUBBLE && state_p1 != BUBBLE) bubble_count <= sat_inc(bubble_count);
      else if (state_nxt == BUBBLE && !hold_en)      bubble_count <= sat_inc(bubble_count);
      if (state_p1 == FULL && !ex_ready)             stall_count  <= sat_inc(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm;
  logic        flush, ex_ready;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [63:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [63:0] memwb_data;
  logic        ex_valid;
  logic [63:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_alu_op;
  logic        ex_shift;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic        illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] bubble_count, stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(64), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .flush(flush), .ex_ready(ex_ready),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_op(ex_alu_op), .ex_shift(ex_shift), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_store_data(ex_store_data),
`ifdef ALU_ISSUE_PERF_EN
    .bubble_count(bubble_count), .stall_count(stall_count),
`endif
    .illegal(illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm);
    id_valid    = 1'b1;
    id_opcode   = op;
    id_funct3   = f3;
    id_funct7b5 = f7;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
    id_rs1_data = d1;
    id_rs2_data = d2;
    id_imm      = imm;
  endtask

  task automatic idle();
    id_valid = 1'b0;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    issue(7'h0, 3'h0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    idle();
    clear_fwd();

    // Reset state
    #12;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_a", ex_a, 64'h0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_alu_op", ex_alu_op, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type SUB x1 = x5 - x6
    issue(7'b0110011, 3'b000, 1'b1, 5'd5, 5'd6, 5'd1, 64'd10, 64'd3, 64'h0);
    #1 check("sub_id_ready", id_ready, 1'b1);
    tick();
    check("sub_valid", ex_valid, 1'b1);
    check("sub_a", ex_a, 64'd10);
    check("sub_b", ex_b, 64'd3);
    check("sub_op", ex_alu_op, 4'b0110);
    check("sub_shift", ex_shift, 1'b0);
    check("sub_rw", ex_reg_write, 1'b1);

    // SLLI x3 = x2 << 4
    issue(7'b0010011, 3'b001, 1'b0, 5'd2, 5'd0, 5'd3, 64'd1, 64'd0, 64'd4);
    tick();
    check("slli_op", ex_alu_op, 4'b0010);
    check("slli_shift", ex_shift, 1'b1);
    check("slli_b", ex_b, 64'd4);
    check("slli_a", ex_a, 64'd1);

    // Forwarding priority on ADD x8 = x5 + x6
    issue(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd6, 5'd8, 64'd10, 64'd3, 64'h0);
    tick();
    idle();
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 64'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_data = 64'hBB;
    #1 check("fwd_exmem_a", ex_a, 64'hAA);
    exmem_rd = 5'd0;
    #1 check("fwd_memwb_a", ex_a, 64'hBB);
    exmem_rd = 5'd6; exmem_result = 64'h77;
    #1 check("fwd_exmem_b", ex_b, 64'h77);
    check("fwd_memwb_a2", ex_a, 64'hBB);
    clear_fwd();
    tick();
    check("idle_valid", ex_valid, 1'b0);

    // Load-use: ld x7, then ADD x9 = x7 + x3
    issue(7'b0000011, 3'b011, 1'b0, 5'd2, 5'd0, 5'd7, 64'd100, 64'd0, 64'd8);
    tick();
    check("ld_valid", ex_valid, 1'b1);
    check("ld_mem_read", ex_mem_read, 1'b1);
    check("ld_a", ex_a, 64'd100);
    check("ld_b", ex_b, 64'd8);
    issue(7'b0110011, 3'b000, 1'b0, 5'd7, 5'd3, 5'd9, 64'd0, 64'd5, 64'h0);
    #1 check("lu_id_ready", id_ready, 1'b0);
    tick();
    check("lu_bubble_valid", ex_valid, 1'b0);
    check("lu_bubble_ready", id_ready, 1'b1);
    tick();
    idle();
    memwb_reg_write = 1'b1; memwb_rd = 5'd7; memwb_data = 64'h1234;
    #1 check("lu_add_valid", ex_valid, 1'b1);
    check("lu_add_a", ex_a, 64'h1234);
    check("lu_add_b", ex_b, 64'd5);
    check("lu_add_rd", ex_rd, 5'd9);
    clear_fwd();

    // Stall: OR x12 = x10 | x11 held three cycles, AND waiting in ID
    issue(7'b0110011, 3'b110, 1'b0, 5'd10, 5'd11, 5'd12, 64'hF0, 64'h0F, 64'h0);
    tick();
    ex_ready = 1'b0;
    issue(7'b0110011, 3'b111, 1'b0, 5'd13, 5'd14, 5'd15, 64'd7, 64'd3, 64'h0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd10; exmem_result = 64'h55;
    #1 check("stall0_ready", id_ready, 1'b0);
    check("stall0_a", ex_a, 64'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      clear_fwd();
      #1;
      check($sformatf("stall%0d_ready", i + 1), id_ready, 1'b0);
      check($sformatf("stall%0d_valid", i + 1), ex_valid, 1'b1);
      check($sformatf("stall%0d_op", i + 1), ex_alu_op, 4'b0001);
      check($sformatf("stall%0d_a", i + 1), ex_a, 64'h55);
      check($sformatf("stall%0d_rd", i + 1), ex_rd, 5'd12);
    end
    ex_ready = 1'b1;
    #1 check("unstall_ready", id_ready, 1'b1);
    tick();
    check("and_op", ex_alu_op, 4'b0000);
    check("and_a", ex_a, 64'd7);
    check("and_b", ex_b, 64'd3);
    check("and_rd", ex_rd, 5'd15);

    // Flush during a stall
    ex_ready = 1'b0;
    issue(7'b0110011, 3'b110, 1'b0, 5'd1, 5'd2, 5'd3, 64'd1, 64'd2, 64'h0);
    tick();
    flush = 1'b1;
    #1 check("flush_ready", id_ready, 1'b0);
    tick();
    flush = 1'b0;
    idle();
    ex_ready = 1'b1;
    #1 check("flush_valid", ex_valid, 1'b0);

    // Store, branch and R-type with rd=x0, back to back
    issue(7'b0100011, 3'b011, 1'b0, 5'd2, 5'd3, 5'd0, 64'h100, 64'hDEAD, 64'd16);
    tick();
    check("st_mem_write", ex_mem_write, 1'b1);
    check("st_rw", ex_reg_write, 1'b0);
    check("st_b", ex_b, 64'd16);
    check("st_data", ex_store_data, 64'hDEAD);
    issue(7'b1100011, 3'b000, 1'b0, 5'd4, 5'd5, 5'd0, 64'd9, 64'd9, 64'h20);
    tick();
    check("br_op", ex_alu_op, 4'b0110);
    check("br_branch", ex_branch, 1'b1);
    check("br_b", ex_b, 64'd9);
    issue(7'b0110011, 3'b010, 1'b0, 5'd4, 5'd5, 5'd0, 64'd1, 64'd2, 64'h0);
    tick();
    check("slt_op", ex_alu_op, 4'b0111);
    check("x0_rw", ex_reg_write, 1'b0);
    check("slt_valid", ex_valid, 1'b1);

    // Illegal opcode and illegal funct3
    issue(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 64'd1, 64'd2, 64'h0);
    #1 check("ill_ready", id_ready, 1'b1);
    tick();
    idle();
    check("ill_pulse", illegal, 1'b1);
    check("ill_valid", ex_valid, 1'b0);
    tick();
    check("ill_clear", illegal, 1'b0);
    issue(7'b0110011, 3'b011, 1'b0, 5'd1, 5'd2, 5'd3, 64'd1, 64'd2, 64'h0);
    tick();
    idle();
    check("ill_f3_pulse", illegal, 1'b1);
    check("ill_f3_valid", ex_valid, 1'b0);

    // Asynchronous reset while FULL
    issue(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 64'h33, 64'h1, 64'h0);
    tick();
    idle();
    check("pre_rst_valid", ex_valid, 1'b1);
    check("pre_rst_a", ex_a, 64'h33);
    #2 rst_n = 1'b0;
    #1 check("arst_valid", ex_valid, 1'b0);
    check("arst_a", ex_a, 64'h0);
    check("arst_rw", ex_reg_write, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", ex_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage of the 5-stage RV64 pipeline.
- Decodes the ID-stage instruction fields into the 64-bit ALU's control inputs (4-bit ALUOp plus Shift).
- Registers the instruction's operands and applies EX/MEM and MEM/WB forwarding to them.
- Detects load-use hazards and inserts bubbles.
- It is the initiator of the ALU interface; the ALU combinationally consumes ex_a/ex_b/ex_alu_op/ex_shift.

Parameters:
- XLEN, 64, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds an instruction.
- id_ready  out  1  stage accepts the ID instruction this cycle.
- id_opcode  in  7  instr[6:0].
- id_funct3  in  3  instr[14:12].
- id_funct7b5  in  1  instr[30].
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  regfile reads; sign-extended immediate.
- flush  in  1  branch-taken squash.
- ex_ready  in  1  downstream EX/MEM accepts.
- exmem_reg_write, exmem_rd, exmem_result  in  1/RA_W/XLEN  EX/MEM forwarding source.
- memwb_reg_write, memwb_rd, memwb_data  in  1/RA_W/XLEN  MEM/WB forwarding source.
- ex_valid  out  1  EX holds a real instruction.
- ex_a, ex_b  out  XLEN  ALU operands.
- ex_alu_op  out  4  ALU opcode.
- ex_shift  out  1  ALU shift select.
- ex_rd  out  RA_W  destination.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1  control.
- ex_store_data  out  XLEN  forwarded rs2 value.
- illegal  out  1  one-cycle pulse on an unsupported accepted opcode.

Behaviour:
- Reset (async, rst_n=0):
  - State EMPTY.
  - All registered outputs 0; ex_valid=0; illegal=0.
  - An instruction in flight is dropped.
- ALUOp encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLT 0111.
- Decode, R-type (0110011):
  - f3=000: ADD if f7b5=0, SUB if f7b5=1.
  - f3=111: AND. f3=110: OR. f3=010: SLT.
  - f3=001: ADD with shift=1 (SLL).
- Decode, I-type ALU (0010011):
  - Same f3 map; f7b5 ignored (always ADD); b=imm.
- Decode, other opcodes:
  - Load (0000011): ADD, b=imm, mem_read=1, reg_write=1.
  - Store (0100011): ADD, b=imm, mem_write=1, reg_write=0.
  - Branch (1100011): SUB, b=rs2, branch=1, reg_write=0.
- reg_write=1 for R-type and I-type, forced 0 when rd=0.
- Any other opcode or f3 is illegal: NOP issued (ex_valid=0), illegal=1 for one cycle.
- Forwarding (combinational on the registered rs1/rs2 values):
  - EX/MEM match has priority over MEM/WB.
  - A match requires reg_write=1, rd≠0 and rd equal to the source register.
  - ex_b uses the forwarded rs2 value unless the immediate is selected.
  - ex_store_data is always the forwarded rs2 value.
- States: EMPTY, FULL, BUBBLE.
- Load-use hazard: ex_valid & ex_mem_read & ex_rd≠0, and ex_rd equals id_rs1, or equals id_rs2 when rs2 is used (R-type, store, branch).
- Transitions (evaluated each edge):
  - flush=1: next state EMPTY and ex_valid=0, regardless of id_valid or ex_ready. id_ready=0 this cycle.
  - FULL & ~ex_ready: hold every field.
    - On each stall cycle, capture the forwarded rs1/rs2 values into the operand registers so they survive retirement of the source.
    - id_ready=0.
  - Load-use hazard & id_valid & (ex_ready | ~ex_valid): go to BUBBLE, ex_valid=0, id_ready=0.
  - BUBBLE → next cycle the ID instruction is re-evaluated; the hazard is gone because the load has moved on.
  - Otherwise id_ready=1:
    - id_valid=1 → load fields, FULL.
    - id_valid=0 → EMPTY.
- Latency: one cycle from the ID handshake to ex_valid.
- Throughput: one instruction per cycle with no hazard.
- No instruction is duplicated or lost across a stall.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined:
  - Adds outputs bubble_count[31:0] and stall_count[31:0], cleared by rst_n.
  - bubble_count increments on each cycle a load-use bubble is inserted.
  - stall_count increments each cycle FULL & ~ex_ready.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- R-type SUB, rs1=5 (data 10), rs2=6 (data 3), ex_ready=1 → next cycle ex_a=10, ex_b=3, ex_alu_op=0110, ex_shift=0, ex_valid=1.
- SLLI with imm=4, rs1 data 1 → ex_alu_op=0010, ex_shift=1, ex_b=4.
- Forwarding: exmem_rd=5 with result 0xAA and memwb_rd=5 with data 0xBB, both reg_write=1 → ex_a=0xAA. With exmem_rd=0 → ex_a=0xBB.
- Load-use: `ld x7` in EX, then ADD using x7 → one ex_valid=0 bubble and id_ready=0 for one cycle; the ADD issues the following cycle.
- Stall and flush:
  - ex_ready=0 for 3 cycles → ex outputs stable and id_ready=0 throughout.
  - flush=1 during the stall → ex_valid=0 next cycle.
- Reset and illegal:
  - rst_n asserted mid-FULL → ex_valid=0 immediately (async).
  - Opcode 1111111 → illegal pulse of 1 cycle and ex_valid=0.
